// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master side is the operand source and the result consumer; the slave side is the adder.
interface adder_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract unit built from CHUNK-bit ripple slices.
// The operand register is followed by one register per slice; the last slice loads the output flags.
module adder_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    adder_pipe_if.slave io
);
    localparam int STAGES = WIDTH / CHUNK;

    // Register p feeds slice p: operands skew forward, finished sum chunks deskew forward.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  opa_q  [STAGES];
    logic [WIDTH-1:0]  opa_d  [STAGES];
    logic [WIDTH-1:0]  opb_q  [STAGES];
    logic [WIDTH-1:0]  opb_d  [STAGES];
    logic [WIDTH-1:0]  psum_q [STAGES];
    logic [WIDTH-1:0]  psum_d [STAGES];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             stall;
    logic             advance;
    logic [CHUNK:0]   fin_add;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_msb_cin;

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    assign stall   = out_valid_q & ~io.out_ready;
    assign advance = ena & ~stall;

    assign fin_add = add_chunk(opa_q[STAGES-1][WIDTH-1 -: CHUNK],
                               opb_q[STAGES-1][WIDTH-1 -: CHUNK],
                               cry_q[STAGES-1]);

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    always_comb begin
        fin_sum                    = psum_q[STAGES-1];
        fin_sum[WIDTH-1 -: CHUNK]  = fin_add[CHUNK-1:0];
        fin_msb_cin                = fin_sum[WIDTH-1] ^ opa_q[STAGES-1][WIDTH-1]
                                     ^ opb_q[STAGES-1][WIDTH-1];
    end

    always_comb begin
        logic [CHUNK:0] mid_add;
        mid_add     = '0;
        vld_d       = vld_q;
        cry_d       = cry_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        psum_d      = psum_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        if (advance) begin
            vld_d[0]  = io.in_valid;
            opa_d[0]  = io.a;
            opb_d[0]  = io.op ? ~io.b : io.b;
            cry_d[0]  = io.op | io.cin;
            psum_d[0] = '0;

            for (int s = 0; s < STAGES - 1; s++) begin
                mid_add                         = add_chunk(opa_q[s][s*CHUNK +: CHUNK],
                                                            opb_q[s][s*CHUNK +: CHUNK],
                                                            cry_q[s]);
                vld_d[s+1]                      = vld_q[s];
                opa_d[s+1]                      = opa_q[s];
                opb_d[s+1]                      = opb_q[s];
                cry_d[s+1]                      = mid_add[CHUNK];
                psum_d[s+1]                     = psum_q[s];
                psum_d[s+1][s*CHUNK +: CHUNK]   = mid_add[CHUNK-1:0];
            end

            out_valid_d = vld_q[STAGES-1];
            if (vld_q[STAGES-1]) begin
                sum_d  = fin_sum;
                cout_d = fin_add[CHUNK];
                ovf_d  = fin_add[CHUNK] ^ fin_msb_cin;
                zero_d = ~|fin_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                opa_q[s]  <= '0;
                opb_q[s]  <= '0;
                psum_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            cry_q       <= cry_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            psum_q      <= psum_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign io.in_ready  = ~stall;
    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;
    assign io.zero      = zero_q;
endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: directed sequences on an 8/4 instance,
// randomised traffic with backpressure and enable gaps on 16/4 and 8/8 instances.
module tb_adder_pipe;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n, rst_r_n;
    logic ena0, ena_r;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t q0[$], q1[$], q2[$];
    int   ret0[$];

    adder_pipe_if #(.WIDTH(8))  if0 ();
    adder_pipe_if #(.WIDTH(16)) if1 ();
    adder_pipe_if #(.WIDTH(8))  if2 ();

    adder_pipe #(.WIDTH(8),  .CHUNK(4)) u0 (.clk(clk), .rst_n(rst0_n),  .ena(ena0),  .io(if0));
    adder_pipe #(.WIDTH(16), .CHUNK(4)) u1 (.clk(clk), .rst_n(rst_r_n), .ena(ena_r), .io(if1));
    adder_pipe #(.WIDTH(8),  .CHUNK(8)) u2 (.clk(clk), .rst_n(rst_r_n), .ena(ena_r), .io(if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic op);
        longint m, ua, ub, sa, sb, ci, full, sres;
        exp_t   r;
        m    = longint'(1) << w;
        ua   = longint'(a) % m;
        ub   = longint'(b) % m;
        ci   = cin ? 1 : 0;
        full = op ? (ua - ub) : (ua + ub + ci);
        if (full < 0)  full = full + m;
        if (full >= m) full = full - m;
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        sres = op ? (sa - sb) : (sa + sb + ci);
        r.sum  = 16'(full);
        r.cout = op ? (ua >= ub) : ((ua + ub + ci) >= m);
        r.ovf  = (sres >= m / 2) || (sres < -(m / 2));
        r.zero = (full == 0);
        return r;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o, input logic z);
        exp_t r;
        r.sum = s; r.cout = c; r.ovf = o; r.zero = z;
        return r;
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = 16'((32'd1 << w) - 32'd1);
            2: r = 16'(32'd1 << (w - 1));
            3: r = 16'((32'd1 << (w - 1)) - 32'd1);
            default: ;
        endcase
        if (w < 16) r = r & 16'((32'd1 << w) - 32'd1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chk_res(input string name, input exp_t act, input exp_t req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got sum=%0h cout=%0b ovf=%0b zero=%0b, required sum=%0h cout=%0b ovf=%0b zero=%0b",
                     name, act.sum, act.cout, act.ovf, act.zero, req.sum, req.cout, req.ovf, req.zero);
        end
    endtask

    // Monitors: a beat retires on an edge where out_valid, out_ready and ena are all high.
    exp_t m0_act, m0_e, m1_act, m1_e, m2_act, m2_e;

    always @(negedge clk) begin
        if (rst0_n && if0.out_valid && if0.out_ready && ena0) begin
            m0_act = {8'h00, if0.sum, if0.cout, if0.ovf, if0.zero};
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d0_extra_beat: got sum=%0h, required no beat", if0.sum);
            end else begin
                m0_e = q0.pop_front();
                chk_res("d0_result", m0_act, m0_e);
                ret0.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_r_n && if1.out_valid && if1.out_ready && ena_r) begin
            m1_act = {if1.sum, if1.cout, if1.ovf, if1.zero};
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d1_extra_beat: got sum=%0h, required no beat", if1.sum);
            end else begin
                m1_e = q1.pop_front();
                chk_res("d1_result", m1_act, m1_e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_r_n && if2.out_valid && if2.out_ready && ena_r) begin
            m2_act = {8'h00, if2.sum, if2.cout, if2.ovf, if2.zero};
            if (q2.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d2_extra_beat: got sum=%0h, required no beat", if2.sum);
            end else begin
                m2_e = q2.pop_front();
                chk_res("d2_result", m2_act, m2_e);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic op, input exp_t e, output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        if0.in_valid = 1'b1;
        if0.a = a; if0.b = b; if0.cin = cin; if0.op = op;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if0.in_ready && ena0) begin
                q0.push_back(e);
                acc_cyc = cyc;
                done    = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL d0_accept_timeout: got no acceptance in 20 cycles, required acceptance");
        end
    endtask

    task automatic idle0();
        if0.in_valid = 1'b0;
    endtask

    task automatic drain0(input string name);
        for (int i = 0; i < 40 && q0.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, 32'(q0.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc[6];
        int dummy;
        logic [7:0] ra, rb;
        logic ci, o;
        exp_t e_b1, e_a;
        exp_t tmp_e;
        logic [15:0] t16;
        bit pend1, pend2;

        rst0_n = 1'b0; rst_r_n = 1'b0; ena0 = 1'b1; ena_r = 1'b1;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.op = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.op = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.op = 1'b0; if2.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_sum",       32'(if0.sum),       32'd0);
        chk("rst_flags",     32'({if0.cout, if0.ovf, if0.zero}), 32'd0);
        chk("rst_in_ready",  32'(if0.in_ready),  32'd1);
        #10;
        rst0_n = 1'b1; rst_r_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic corners, issued back-to-back.
        send0(8'hFF, 8'h01, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1), dummy);
        send0(8'h80, 8'h01, 1'b0, 1'b1, mk(16'h007F, 1'b1, 1'b1, 1'b0), dummy);
        send0(8'h03, 8'h05, 1'b0, 1'b1, mk(16'h00FE, 1'b0, 1'b0, 1'b0), dummy);
        send0(8'h7F, 8'h00, 1'b1, 1'b0, mk(16'h0080, 1'b0, 1'b1, 1'b0), dummy);
        send0(8'h0F, 8'h01, 1'b0, 1'b0, mk(16'h0010, 1'b0, 1'b0, 1'b0), dummy);
        send0(8'h05, 8'h05, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1), dummy);
        idle0();
        drain0("d0_directed_drain");

        // Six back-to-back beats: results must retire on consecutive cycles, two edges later.
        ret0.delete();
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); ci = 1'($urandom); o = 1'($urandom);
            send0(ra, rb, ci, o, model(8, {8'h00, ra}, {8'h00, rb}, ci, o), acc[i]);
        end
        idle0();
        drain0("d0_stream_drain");
        chk("d0_stream_count", 32'(ret0.size()), 32'd6);
        for (int i = 0; i < 6 && i < ret0.size(); i++)
            chk("d0_stream_timing", 32'(ret0[i]), 32'(acc[0] + i + 3));

        // Backpressure with three beats in flight, then a beat offered during the stall.
        if0.out_ready = 1'b0;
        e_b1 = model(8, 16'h0033, 16'h0044, 1'b1, 1'b0);
        send0(8'h33, 8'h44, 1'b1, 1'b0, e_b1, dummy);
        send0(8'hC0, 8'h41, 1'b0, 1'b1, model(8, 16'h00C0, 16'h0041, 1'b0, 1'b1), dummy);
        send0(8'h99, 8'h99, 1'b0, 1'b0, model(8, 16'h0099, 16'h0099, 1'b0, 1'b0), dummy);
        if0.in_valid = 1'b1; if0.a = 8'h12; if0.b = 8'h34; if0.cin = 1'b0; if0.op = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(if0.in_ready),  32'd0);
            chk("bp_out_valid", 32'(if0.out_valid), 32'd1);
            chk_res("bp_frozen", {8'h00, if0.sum, if0.cout, if0.ovf, if0.zero}, e_b1);
            @(posedge clk); #1;
        end
        if0.out_ready = 1'b1;
        send0(8'h12, 8'h34, 1'b0, 1'b0, mk(16'h0046, 1'b0, 1'b0, 1'b0), dummy);
        idle0();
        drain0("d0_bp_drain");

        // Enable held low for three edges while a result is presented and a beat is offered.
        e_a = model(8, 16'h00A5, 16'h005A, 1'b1, 1'b0);
        send0(8'hA5, 8'h5A, 1'b1, 1'b0, e_a, dummy);
        send0(8'h10, 8'h20, 1'b0, 1'b1, model(8, 16'h0010, 16'h0020, 1'b0, 1'b1), dummy);
        idle0();
        @(posedge clk); #1;
        ena0 = 1'b0;
        if0.in_valid = 1'b1; if0.a = 8'h21; if0.b = 8'h11; if0.cin = 1'b0; if0.op = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ena_out_valid", 32'(if0.out_valid), 32'd1);
            chk_res("ena_frozen", {8'h00, if0.sum, if0.cout, if0.ovf, if0.zero}, e_a);
            chk("ena_in_ready", 32'(if0.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        ena0 = 1'b1;
        send0(8'h21, 8'h11, 1'b0, 1'b0, mk(16'h0032, 1'b0, 1'b0, 1'b0), dummy);
        idle0();
        drain0("d0_ena_drain");

        // Asynchronous reset with two beats in flight.
        send0(8'h44, 8'h22, 1'b0, 1'b0, mk(16'h0066, 1'b0, 1'b0, 1'b0), dummy);
        send0(8'h50, 8'h07, 1'b0, 1'b1, mk(16'h0049, 1'b1, 1'b0, 1'b0), dummy);
        idle0();
        #2;
        rst0_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_mid_sum",       32'(if0.sum),       32'd0);
        chk("rst_mid_in_ready",  32'(if0.in_ready),  32'd1);
        q0.delete();
        #4;
        rst0_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(if0.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        send0(8'h01, 8'hFF, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b0, 1'b0), dummy);
        idle0();
        drain0("d0_post_rst_drain");

        // Randomised traffic on the 16/4 and 8/8 instances with backpressure and enable gaps.
        pend1 = 1'b0; pend2 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            ena_r         = ($urandom_range(0, 9) != 0);
            if1.out_ready = ($urandom_range(0, 3) != 0);
            if2.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend1) begin
                if1.in_valid = ($urandom_range(0, 3) != 0);
                if1.a = pick(16); if1.b = pick(16);
                if1.cin = 1'($urandom); if1.op = 1'($urandom);
            end
            if (!pend2) begin
                if2.in_valid = ($urandom_range(0, 3) != 0);
                t16 = pick(8); if2.a = t16[7:0];
                t16 = pick(8); if2.b = t16[7:0];
                if2.cin = 1'($urandom); if2.op = 1'($urandom);
            end
            @(negedge clk);
            if (if1.in_valid && if1.in_ready && ena_r) begin
                tmp_e = model(16, if1.a, if1.b, if1.cin, if1.op);
                q1.push_back(tmp_e);
                pend1 = 1'b0;
            end else begin
                pend1 = if1.in_valid;
            end
            if (if2.in_valid && if2.in_ready && ena_r) begin
                tmp_e = model(8, {8'h00, if2.a}, {8'h00, if2.b}, if2.cin, if2.op);
                q2.push_back(tmp_e);
                pend2 = 1'b0;
            end else begin
                pend2 = if2.in_valid;
            end
            @(posedge clk); #1;
        end
        if1.in_valid = 1'b0; if2.in_valid = 1'b0;
        if1.out_ready = 1'b1; if2.out_ready = 1'b1; ena_r = 1'b1;
        for (int i = 0; i < 60 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        #1;
        chk("d1_drain", 32'(q1.size()), 32'd0);
        chk("d2_drain", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit ripple adder: a WIDTH-bit add/subtract unit split into CHUNK-bit ripple slices, with one register stage per slice.
- Provides a valid/ready handshake on input and output, stall on backpressure, and carry/overflow/zero flags.
- Sits between an operand source and a result consumer inside the tile; throughput is one operation per cycle when not stalled.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage. STAGES = WIDTH/CHUNK; STAGES >= 1.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  global enable; when 0, all registers hold
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when op=ADD
- op  input  1  0=ADD (a+b+cin), 1=SUB (a-b, computed as a+~b+1)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for SUB, 1 = no borrow (a >= b unsigned)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

Behaviour:
- Reset (rst_n=0, async): all stage valid bits, sum, cout, ovf and zero clear to 0. in_ready follows its combinational definition (1 after reset). In-flight operations are discarded; no output beat appears for them after reset release.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall.
- Advance: the pipeline advances on a clk edge iff ena=1 and stall=0. When it advances, every stage shifts forward by one.
- Bubbles: with no in_valid, the stage-0 valid loads 0.
- Acceptance: a beat is accepted on an edge where in_valid & in_ready & ena.
- Stage 0 operand preparation: b_eff = op ? ~b : b; c0 = op ? 1 : cin.
- Stage i (0..STAGES-1) datapath:
  - Adds chunk i of a and b_eff plus the carry registered by stage i-1 (c0 for stage 0).
  - Registers: the sum chunk; the carry out; for the last stage only, the carry into the MSB.
  - Unused upper operand chunks travel forward registered (skew).
  - Completed lower sum chunks travel forward registered (deskew).
- Output register: the final stage drives sum, cout, ovf and zero directly. These registers update only when the pipeline advances with the final stage holding valid data. With no valid beat, they hold their last value; out_valid marks validity.
- Latency:
  - A beat accepted at edge k produces out_valid=1 after edge k+STAGES.
  - Results leave in acceptance order; no reordering.
  - Back-to-back beats yield back-to-back results.
- Backpressure: while stall=1, every register holds and in_ready=0. A beat presented during stall is not accepted, and the source must hold it. When out_ready rises, the output beat retires on that edge and the pipeline advances in the same edge.
- ena=0: all registers hold, including valid bits. out_valid remains as held. in_ready still = ~stall, but no acceptance occurs while ena=0.
- Arithmetic is modulo 2^WIDTH. ovf is meaningful for signed interpretation only; cout is meaningful for unsigned only.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.
- cin is ignored when op=SUB.

Test Plan:
- WIDTH=8, CHUNK=4, ADD, a=0xFF, b=0x01, cin=0 -> after 2 cycles: sum=0x00, cout=1, ovf=0, zero=1.
- SUB, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1, zero=0. SUB, a=0x03, b=0x05 -> sum=0xFE, cout=0, ovf=0.
- ADD with cin=1, a=0x7F, b=0x00 -> sum=0x80, ovf=1, cout=0. Carry crossing the chunk boundary: a=0x0F, b=0x01 -> 0x10.
- Stream of 6 back-to-back beats with out_ready=1 -> 6 consecutive out_valid cycles starting at cycle 2, in order, values matching the golden model.
- Backpressure: out_ready=0 while 3 beats are in flight -> in_ready=0 and outputs frozen. Release out_ready -> all 3 results delivered in order; none lost or duplicated.
- Assert rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 and sum=0 immediately (async). After release, no stale beats emerge.
- ena=0 for 3 cycles mid-stream -> no state change. Randomised ADD/SUB across WIDTH=16, CHUNK=4 and WIDTH=8, CHUNK=8 against the reference model.
